// File: rtl/agu_arbiter_pkg.sv
// Shared definitions for the address-generation arbiter: RV32 opcodes, port
// indices and the operand-base decode used by the adder datapath.
package agu_arbiter_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic PORT_LSU  = 1'b0;
    localparam logic PORT_CTRL = 1'b1;

    typedef enum logic [1:0] {
        BASE_RS1,
        BASE_RS1_ALIGN,
        BASE_PC,
        BASE_NONE
    } base_sel_e;

    // BASE_NONE marks an unsupported opcode; it yields address 0 and the illegal flag.
    function automatic base_sel_e decode_base(input logic [6:0] opcode);
        base_sel_e sel;
        case (opcode)
            OP_LOAD, OP_STORE:           sel = BASE_RS1;
            OP_JALR:                     sel = BASE_RS1_ALIGN;
            OP_JAL, OP_AUIPC, OP_BRANCH: sel = BASE_PC;
            default:                     sel = BASE_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/agu_core.sv
// Combinational address generator: operand mux, XLEN adder (carry discarded)
// and the JALR bit-0 clear.
module agu_core
    import agu_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] address_o,
    output logic            illegal_o
);

    base_sel_e       sel;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    always_comb begin
        sel       = decode_base(opcode_i);
        base      = (sel == BASE_PC) ? pc_i : rs1_i;
        sum       = base + imm_i;
        address_o = sum;
        illegal_o = 1'b0;
        case (sel)
            BASE_RS1_ALIGN: address_o = {sum[XLEN-1:1], 1'b0};
            BASE_NONE: begin
                address_o = '0;
                illegal_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/agu_arbiter.sv
// Round-robin arbiter sharing one address adder between the load/store and
// control-flow units, with a one-entry valid/ready registered result stage.
module agu_arbiter
    import agu_arbiter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_opcode,
    input  logic [XLEN-1:0]  req0_rs1,
    input  logic [XLEN-1:0]  req0_pc,
    input  logic [XLEN-1:0]  req0_imm,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_opcode,
    input  logic [XLEN-1:0]  req1_rs1,
    input  logic [XLEN-1:0]  req1_pc,
    input  logic [XLEN-1:0]  req1_imm,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_address,
    output logic             res_port,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_illegal
);

    logic             accept;
    logic             grant;
    logic             fire;
    logic             rr_q, rr_d;
    logic             res_valid_q, res_valid_d;
    logic [XLEN-1:0]  res_address_q, res_address_d;
    logic             res_port_q, res_port_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_illegal_q, res_illegal_d;

    logic [6:0]       sel_opcode;
    logic [XLEN-1:0]  sel_rs1, sel_pc, sel_imm;
    logic [TAG_W-1:0] sel_tag;
    logic [XLEN-1:0]  core_address;
    logic             core_illegal;

    // The output stage can refill in the same cycle it drains.
    always_comb begin
        accept = !res_valid_q || res_ready;
        if (req0_valid && req1_valid) begin
            grant = rr_q;
        end else if (req1_valid) begin
            grant = PORT_CTRL;
        end else begin
            grant = PORT_LSU;
        end
        req0_ready = accept && req0_valid && (grant == PORT_LSU);
        req1_ready = accept && req1_valid && (grant == PORT_CTRL);
        fire       = req0_ready || req1_ready;
    end

    always_comb begin
        sel_opcode = (grant == PORT_CTRL) ? req1_opcode : req0_opcode;
        sel_rs1    = (grant == PORT_CTRL) ? req1_rs1    : req0_rs1;
        sel_pc     = (grant == PORT_CTRL) ? req1_pc     : req0_pc;
        sel_imm    = (grant == PORT_CTRL) ? req1_imm    : req0_imm;
        sel_tag    = (grant == PORT_CTRL) ? req1_tag    : req0_tag;
    end

    agu_core #(
        .XLEN (XLEN)
    ) u_core (
        .opcode_i  (sel_opcode),
        .rs1_i     (sel_rs1),
        .pc_i      (sel_pc),
        .imm_i     (sel_imm),
        .address_o (core_address),
        .illegal_o (core_illegal)
    );

    always_comb begin
        rr_d          = rr_q;
        res_valid_d   = res_valid_q;
        res_address_d = res_address_q;
        res_port_d    = res_port_q;
        res_tag_d     = res_tag_q;
        res_illegal_d = res_illegal_q;
        if (fire) begin
            rr_d          = ~grant;
            res_valid_d   = 1'b1;
            res_address_d = core_address;
            res_port_d    = grant;
            res_tag_d     = sel_tag;
            res_illegal_d = core_illegal;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q          <= PORT_LSU;
            res_valid_q   <= 1'b0;
            res_address_q <= '0;
            res_port_q    <= 1'b0;
            res_tag_q     <= '0;
            res_illegal_q <= 1'b0;
        end else begin
            rr_q          <= rr_d;
            res_valid_q   <= res_valid_d;
            res_address_q <= res_address_d;
            res_port_q    <= res_port_d;
            res_tag_q     <= res_tag_d;
            res_illegal_q <= res_illegal_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_address = res_address_q;
    assign res_port    = res_port_q;
    assign res_tag     = res_tag_q;
    assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_agu_arbiter.sv
// Bench for agu_arbiter: a transaction-level model checked every negedge,
// plus hand-computed literal expectations along a directed sequence.
module tb_agu_arbiter;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] AUIPC  = 7'h17;
    localparam logic [6:0] BRANCH = 7'h63;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [6:0]       req0_opcode = '0;
    logic [XLEN-1:0]  req0_rs1 = '0;
    logic [XLEN-1:0]  req0_pc = '0;
    logic [XLEN-1:0]  req0_imm = '0;
    logic [TAG_W-1:0] req0_tag = '0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [6:0]       req1_opcode = '0;
    logic [XLEN-1:0]  req1_rs1 = '0;
    logic [XLEN-1:0]  req1_pc = '0;
    logic [XLEN-1:0]  req1_imm = '0;
    logic [TAG_W-1:0] req1_tag = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [XLEN-1:0]  res_address;
    logic             res_port;
    logic [TAG_W-1:0] res_tag;
    logic             res_illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    agu_arbiter #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_rs1    (req0_rs1),
        .req0_pc     (req0_pc),
        .req0_imm    (req0_imm),
        .req0_tag    (req0_tag),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_rs1    (req1_rs1),
        .req1_pc     (req1_pc),
        .req1_imm    (req1_imm),
        .req1_tag    (req1_tag),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_address (res_address),
        .res_port    (res_port),
        .res_tag     (res_tag),
        .res_illegal (res_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {illegal, address} straight from the opcode table.
    function automatic logic [32:0] model_addr(input logic [6:0] op, input logic [31:0] rs1,
                                               input logic [31:0] pc, input logic [31:0] imm);
        logic [31:0] s;
        case (op)
            LOAD, STORE: begin s = rs1 + imm; return {1'b0, s}; end
            JALR:        begin s = (rs1 + imm) & 32'hFFFF_FFFE; return {1'b0, s}; end
            JAL, AUIPC, BRANCH: begin s = pc + imm; return {1'b0, s}; end
            default:     return {1'b1, 32'h0};
        endcase
    endfunction

    logic        m_valid = 1'b0;
    logic [31:0] m_addr = '0;
    logic        m_port = 1'b0;
    logic [3:0]  m_tag = '0;
    logic        m_ill = 1'b0;
    logic        m_rr = 1'b0;
    logic        w0 = 1'b0, w1 = 1'b0;
    logic [106:0] p0 = '0, p1 = '0;

    always @(negedge clk) begin : model_p
        logic e_acc, e_r0, e_r1;
        logic [32:0] r;
        if (reset) begin
            m_valid = 1'b0; m_addr = '0; m_port = 1'b0; m_tag = '0; m_ill = 1'b0; m_rr = 1'b0;
            w0 = 1'b0; w1 = 1'b0;
            check("rst_valid", res_valid, 0);
            check("rst_address", res_address, 0);
        end else begin
            e_acc = !m_valid || res_ready;
            e_r0  = e_acc && req0_valid && (!req1_valid || m_rr == 1'b0);
            e_r1  = e_acc && req1_valid && (!req0_valid || m_rr == 1'b1);
            check("req0_ready", req0_ready, e_r0);
            check("req1_ready", req1_ready, e_r1);
            check("res_valid", res_valid, m_valid);
            check("res_address", res_address, m_addr);
            check("res_port", res_port, m_port);
            check("res_tag", res_tag, m_tag);
            check("res_illegal", res_illegal, m_ill);
            if (w0) check("req0_hold", req0_valid && ({req0_opcode, req0_rs1, req0_pc, req0_imm, req0_tag} == p0), 1);
            if (w1) check("req1_hold", req1_valid && ({req1_opcode, req1_rs1, req1_pc, req1_imm, req1_tag} == p1), 1);
            w0 = req0_valid && !e_r0;
            w1 = req1_valid && !e_r1;
            p0 = {req0_opcode, req0_rs1, req0_pc, req0_imm, req0_tag};
            p1 = {req1_opcode, req1_rs1, req1_pc, req1_imm, req1_tag};
            if (e_r0) begin
                r = model_addr(req0_opcode, req0_rs1, req0_pc, req0_imm);
                m_valid = 1'b1; m_addr = r[31:0]; m_ill = r[32]; m_port = 1'b0; m_tag = req0_tag; m_rr = 1'b1;
            end else if (e_r1) begin
                r = model_addr(req1_opcode, req1_rs1, req1_pc, req1_imm);
                m_valid = 1'b1; m_addr = r[31:0]; m_ill = r[32]; m_port = 1'b1; m_tag = req1_tag; m_rr = 1'b0;
            end else if (m_valid && res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [6:0] op, input logic [31:0] rs1,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] tag);
        req0_valid = v; req0_opcode = op; req0_rs1 = rs1; req0_pc = pc; req0_imm = imm; req0_tag = tag;
        $display("drive port0 valid=%0d op=0x%0h rs1=0x%0h pc=0x%0h imm=0x%0h tag=%0d", v, op, rs1, pc, imm, tag);
    endtask

    task automatic set1(input logic v, input logic [6:0] op, input logic [31:0] rs1,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] tag);
        req1_valid = v; req1_opcode = op; req1_rs1 = rs1; req1_pc = pc; req1_imm = imm; req1_tag = tag;
        $display("drive port1 valid=%0d op=0x%0h rs1=0x%0h pc=0x%0h imm=0x%0h tag=%0d", v, op, rs1, pc, imm, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cyc();
        reset = 1'b0;
        check("lit_reset_valid", res_valid, 0);
        check("lit_reset_tag", res_tag, 0);

        // Single LOAD on port 0
        set0(1'b1, LOAD, 32'h1000, 32'h0, 32'h10, 4'd3);
        #1 check("lit_t1_ready0", req0_ready, 1);
        cyc();
        check("lit_t1_valid", res_valid, 1);
        check("lit_t1_addr", res_address, 32'h1010);
        check("lit_t1_port", res_port, 0);
        check("lit_t1_tag", res_tag, 3);
        set0(1'b0, LOAD, 32'h1000, 32'h0, 32'h10, 4'd3);
        cyc();
        check("lit_t1_drain", res_valid, 0);

        // Both ports contending from reset: strict alternation
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set0(1'b1, STORE, 32'h200, 32'h0, 32'h4, 4'd1);
        set1(1'b1, BRANCH, 32'h0, 32'h80, 32'hFFFF_FFF8, 4'd2);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("lit_rr_port", res_port, (k - 1) % 2);
            check("lit_rr_addr", res_address, ((k % 2) == 1) ? 32'h204 : 32'h78);
            if (k == 3) set0(1'b0, STORE, 32'h200, 32'h0, 32'h4, 4'd1);
            if (k == 4) set1(1'b0, BRANCH, 32'h0, 32'h80, 32'hFFFF_FFF8, 4'd2);
        end

        // Backpressure with one result pending
        res_ready = 1'b0;
        set0(1'b1, STORE, 32'h500, 32'h0, 32'h20, 4'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lit_bp_ready0", req0_ready, 0);
            check("lit_bp_ready1", req1_ready, 0);
            check("lit_bp_addr", res_address, 32'h78);
            check("lit_bp_valid", res_valid, 1);
            cyc();
        end
        res_ready = 1'b1;
        #1 check("lit_bp_release_ready0", req0_ready, 1);
        cyc();
        check("lit_bp_addr_new", res_address, 32'h520);
        check("lit_bp_tag_new", res_tag, 5);

        // JALR bit-0 clear and adder wrap
        set0(1'b1, JALR, 32'h3, 32'h0, 32'h0, 4'd6);
        cyc();
        check("lit_jalr_addr", res_address, 32'h2);
        set0(1'b1, LOAD, 32'hFFFF_FFFC, 32'h0, 32'h8, 4'd7);
        cyc();
        check("lit_wrap_addr", res_address, 32'h4);
        set0(1'b0, LOAD, 32'hFFFF_FFFC, 32'h0, 32'h8, 4'd7);

        // Illegal opcode on port 1, then AUIPC
        set1(1'b1, 7'h33, 32'h55, 32'h99, 32'h7, 4'd8);
        cyc();
        check("lit_ill_flag", res_illegal, 1);
        check("lit_ill_addr", res_address, 0);
        check("lit_ill_port", res_port, 1);
        set1(1'b1, AUIPC, 32'h0, 32'h100, 32'h1000, 4'd9);
        cyc();
        check("lit_auipc_addr", res_address, 32'h1100);
        check("lit_auipc_ill", res_illegal, 0);
        set1(1'b0, AUIPC, 32'h0, 32'h100, 32'h1000, 4'd9);
        cyc();

        // Reset with a result pending
        set0(1'b1, LOAD, 32'h40, 32'h0, 32'h4, 4'd10);
        cyc();
        set0(1'b0, LOAD, 32'h40, 32'h0, 32'h4, 4'd10);
        res_ready = 1'b0;
        check("lit_pre_rst_valid", res_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("lit_async_rst_valid", res_valid, 0);
        check("lit_async_rst_addr", res_address, 0);
        cyc();
        res_ready = 1'b1;
        reset = 1'b0;
        set0(1'b1, STORE, 32'h200, 32'h0, 32'h4, 4'd11);
        set1(1'b1, BRANCH, 32'h0, 32'h80, 32'hFFFF_FFF8, 4'd12);
        #1;
        check("lit_post_rst_ready0", req0_ready, 1);
        check("lit_post_rst_ready1", req1_ready, 0);
        cyc();
        check("lit_post_rst_port", res_port, 0);
        check("lit_post_rst_addr", res_address, 32'h204);
        set0(1'b0, STORE, 32'h200, 32'h0, 32'h4, 4'd11);
        cyc();
        check("lit_post_rst_port1", res_port, 1);
        check("lit_post_rst_addr1", res_address, 32'h78);
        set1(1'b0, BRANCH, 32'h0, 32'h80, 32'hFFFF_FFF8, 4'd12);
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
